// File: rtl/divmod_iter_pkg.sv
// Shared types and helpers for the iterative divider and its users in the Cpu.
package pkg_divmod;

   // Widest operand any divider instance is built for; sizes the request/result structs.
   localparam int unsigned DivmodMaxW = 64;

   // Operating mode as driven on unsgn_or_sgn.
   localparam logic DivmodUnsgn = 1'b0;
   localparam logic DivmodSgn   = 1'b1;

   // Controller states.
   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StPrep = 3'd1,
      StIter = 3'd2,
      StFix  = 3'd3,
      StDone = 3'd4
   } StrcDivmodState;

   // Request bundle as assembled by the execute stage.
   typedef struct packed {
      logic                  enable;
      logic                  unsgn_or_sgn;
      logic                  flush;
      logic [DivmodMaxW-1:0] num;
      logic [DivmodMaxW-1:0] denom;
   } StrcInDivmod;

   // Result bundle as consumed by the execute stage.
   typedef struct packed {
      logic [DivmodMaxW-1:0] quot;
      logic [DivmodMaxW-1:0] rem;
      logic                  can_accept_cmd;
      logic                  data_ready;
      logic                  div_by_zero;
   } StrcOutDivmod;

   // Number of iteration cycles needed to retire all quotient bits.
   function automatic int unsigned divmod_iter_count(input int unsigned width,
                                                     input int unsigned bpc);
      return width / bpc;
   endfunction

endpackage

// File: rtl/divmod_iter_step.sv
// One iteration of restoring division retiring BITS_PER_CYCLE quotient bits, MSB first.
module divmod_step
   import pkg_divmod::*;
#(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic [WIDTH+BITS_PER_CYCLE-1:0] rem_i,
   input  logic [WIDTH-1:0]                div_i,
   input  logic [BITS_PER_CYCLE-1:0]       bits_i,
   output logic [WIDTH+BITS_PER_CYCLE-1:0] rem_o,
   output logic [BITS_PER_CYCLE-1:0]       quot_o
);

   logic [WIDTH+BITS_PER_CYCLE-1:0] acc;
   logic [WIDTH+BITS_PER_CYCLE-1:0] dvs;

   // Shift in one numerator bit at a time and subtract the divisor whenever it fits.
   always_comb begin
      acc    = rem_i;
      dvs    = {{BITS_PER_CYCLE{1'b0}}, div_i};
      quot_o = '0;
      for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
         acc = {acc[WIDTH+BITS_PER_CYCLE-2:0], bits_i[i]};
         if (acc >= dvs) begin
            acc       = acc - dvs;
            quot_o[i] = 1'b1;
         end else begin
            quot_o[i] = 1'b0;
         end
      end
      rem_o = acc;
   end

endmodule

// File: rtl/divmod_iter.sv
// Multi-cycle signed/unsigned divider with quotient and remainder, flush and
// divide-by-zero reporting, using the enable / can_accept_cmd / data_ready handshake.
module divmod_iter
   import pkg_divmod::*;
#(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             unsgn_or_sgn,
   input  logic             flush,
   input  logic [WIDTH-1:0] num,
   input  logic [WIDTH-1:0] denom,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             can_accept_cmd,
   output logic             data_ready,
   output logic             div_by_zero
);

   localparam int unsigned NIter = divmod_iter_count(WIDTH, BITS_PER_CYCLE);
   localparam int unsigned CntW  = $clog2(NIter + 1);
   localparam int unsigned PremW = WIDTH + BITS_PER_CYCLE;

   if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
      $error("divmod_iter: BITS_PER_CYCLE must divide WIDTH");
   end
   if ((BITS_PER_CYCLE != 1) && (BITS_PER_CYCLE != 2) && (BITS_PER_CYCLE != 4)) begin : g_bad_radix
      $error("divmod_iter: BITS_PER_CYCLE must be 1, 2 or 4");
   end

   StrcDivmodState   state_q, state_d;
   logic [WIDTH-1:0] num_q, num_d;        // numerator as latched, reused for divide-by-zero
   logic [WIDTH-1:0] den_q, den_d;        // latched denominator, then its magnitude
   logic             mode_q, mode_d;
   logic             neg_quot_q, neg_quot_d;
   logic             neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0] shf_q, shf_d;        // numerator bits shift out, quotient bits shift in
   logic [PremW-1:0] prem_q, prem_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             rdy_q, rdy_d;
   logic             dbz_q, dbz_d;

   logic [PremW-1:0]          step_rem;
   logic [BITS_PER_CYCLE-1:0] step_quot;

   divmod_step #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .rem_i  (prem_q),
      .div_i  (den_q),
      .bits_i (shf_q[WIDTH-1 -: BITS_PER_CYCLE]),
      .rem_o  (step_rem),
      .quot_o (step_quot)
   );

   // State and datapath registers; reset returns everything to an idle, empty divider.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         num_q      <= '0;
         den_q      <= '0;
         mode_q     <= DivmodUnsgn;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         shf_q      <= '0;
         prem_q     <= '0;
         cnt_q      <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         rdy_q      <= 1'b0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         num_q      <= num_d;
         den_q      <= den_d;
         mode_q     <= mode_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         shf_q      <= shf_d;
         prem_q     <= prem_d;
         cnt_q      <= cnt_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         rdy_q      <= rdy_d;
         dbz_q      <= dbz_d;
      end
   end

   // Next-state and datapath control; flush overrides everything, including a new command.
   always_comb begin
      state_d    = state_q;
      num_d      = num_q;
      den_d      = den_q;
      mode_d     = mode_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      shf_d      = shf_q;
      prem_d     = prem_q;
      cnt_d      = cnt_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      rdy_d      = rdy_q;
      dbz_d      = dbz_q;
      if (flush) begin
         state_d = StIdle;
         rdy_d   = 1'b0;
         dbz_d   = 1'b0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (enable) begin
                  num_d   = num;
                  den_d   = denom;
                  mode_d  = unsgn_or_sgn;
                  rdy_d   = 1'b0;
                  dbz_d   = 1'b0;
                  state_d = StPrep;
               end else begin
                  state_d = state_q;
               end
            end
            StPrep: begin
               // Magnitudes: negating MIN wraps to MIN, which reads as 2^(WIDTH-1) unsigned.
               if (mode_q == DivmodSgn) begin
                  neg_quot_d = num_q[WIDTH-1] ^ den_q[WIDTH-1];
                  neg_rem_d  = num_q[WIDTH-1];
                  shf_d      = num_q[WIDTH-1] ? -num_q : num_q;
                  den_d      = den_q[WIDTH-1] ? -den_q : den_q;
               end else begin
                  neg_quot_d = 1'b0;
                  neg_rem_d  = 1'b0;
                  shf_d      = num_q;
                  den_d      = den_q;
               end
               prem_d  = '0;
               cnt_d   = CntW'(NIter);
               state_d = (den_q == '0) ? StFix : StIter;
            end
            StIter: begin
               prem_d  = step_rem;
               shf_d   = {shf_q[WIDTH-BITS_PER_CYCLE-1:0], step_quot};
               cnt_d   = cnt_q - CntW'(1);
               state_d = (cnt_q == CntW'(1)) ? StFix : StIter;
            end
            StFix: begin
               if (den_q == '0) begin
                  quot_d = '1;
                  rem_d  = num_q;
                  dbz_d  = 1'b1;
               end else begin
                  quot_d = neg_quot_q ? -shf_q : shf_q;
                  rem_d  = neg_rem_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
                  dbz_d  = 1'b0;
               end
               rdy_d   = 1'b1;
               state_d = StDone;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   assign quot           = quot_q;
   assign rem            = rem_q;
   assign data_ready     = rdy_q;
   assign div_by_zero    = dbz_q;
   assign can_accept_cmd = (state_q == StIdle) || (state_q == StDone);

endmodule
